// File: rtl/lifo_arb_pkg.sv
// rtl/lifo_arb_pkg.sv - shared types and constants for the LIFO stack arbiter
package lifo_arb_pkg;

  localparam int LIFO_DATA_WIDTH  = 32;
  localparam int LIFO_NUM_CLIENTS = 2;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_PEEK = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Client index following idx, wrapping at n.
  function automatic int next_client(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/lifo_stack_arbiter_if.sv
// rtl/lifo_stack_arbiter_if.sv - client and stack signal bundle for the LIFO stack arbiter
interface lifo_stack_arbiter_if
  import lifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = LIFO_DATA_WIDTH,
  parameter int NUM_CLIENTS = LIFO_NUM_CLIENTS
);

  // Client side
  logic [NUM_CLIENTS-1:0]            Req_In;
  logic [2*NUM_CLIENTS-1:0]          Op_In;
  logic [DATA_WIDTH*NUM_CLIENTS-1:0] Wr_Data_In;
  logic [NUM_CLIENTS-1:0]            Ack_Out;
  logic                              Err_Out;
  logic [DATA_WIDTH-1:0]             Rd_Data_Out;
  logic                              Busy_Out;

  // Stack side
  logic [DATA_WIDTH-1:0]             Stk_Data_Out;
  logic                              Stk_Push_Out;
  logic                              Stk_Pop_Out;
  logic                              Stk_Peek_Out;
  logic [DATA_WIDTH-1:0]             Stk_Data_In;
  logic                              Stk_Empty_In;
  logic                              Stk_Full_In;

  modport slave (
    input  Req_In, Op_In, Wr_Data_In, Stk_Data_In, Stk_Empty_In, Stk_Full_In,
    output Ack_Out, Err_Out, Rd_Data_Out, Busy_Out,
    output Stk_Data_Out, Stk_Push_Out, Stk_Pop_Out, Stk_Peek_Out
  );

  modport master (
    output Req_In, Op_In, Wr_Data_In, Stk_Data_In, Stk_Empty_In, Stk_Full_In,
    input  Ack_Out, Err_Out, Rd_Data_Out, Busy_Out,
    input  Stk_Data_Out, Stk_Push_Out, Stk_Pop_Out, Stk_Peek_Out
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting at the RR pointer
module rr_arbiter #(
  parameter int NUM_CLIENTS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [NUM_CLIENTS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   grant_valid
);

  int   cand;
  logic found;

  // Scan upward from rr_ptr with wraparound; the first requester found wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = 0;
    found     = 1'b0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_CLIENTS) cand = cand - NUM_CLIENTS;
      if (!found && req[IDX_W'(cand)]) begin
        found                 = 1'b1;
        grant[IDX_W'(cand)]   = 1'b1;
        grant_idx             = IDX_W'(cand);
      end
    end
  end

  assign grant_valid = |req;

endmodule

// File: rtl/lifo_stack_arbiter.sv
// rtl/lifo_stack_arbiter.sv - round-robin sequencer sharing one LIFO stack between clients
module lifo_stack_arbiter
  import lifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = LIFO_DATA_WIDTH,
  parameter int NUM_CLIENTS = LIFO_NUM_CLIENTS
) (
  input  logic                 Clk_In,
  input  logic                 Reset_In,
  lifo_stack_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [IDX_W-1:0]       win_q, win_d;
  logic [NUM_CLIENTS-1:0] win_oh_q, win_oh_d;
  op_t                    op_q, op_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [NUM_CLIENTS-1:0] ack_q, ack_d;
  logic                   err_q, err_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;

  logic [NUM_CLIENTS-1:0] grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_valid;
  logic                   exec_push_ok;
  logic                   exec_read_ok;

  rr_arbiter #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_rr_arbiter (
    .req         (bus.Req_In),
    .rr_ptr      (rr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Flags are only meaningful in EXEC; these say whether the stack can take the operation.
  always_comb begin
    exec_push_ok = (state_q == EXEC) && (op_q == OP_PUSH) && !bus.Stk_Full_In;
    exec_read_ok = (state_q == EXEC) && ((op_q == OP_POP) || (op_q == OP_PEEK))
                   && !bus.Stk_Empty_In;
  end

  // Strobes are gated by reset so an aborted transaction never touches the stack.
  assign bus.Stk_Push_Out = Reset_In && exec_push_ok;
  assign bus.Stk_Peek_Out = Reset_In && exec_read_ok;
  assign bus.Stk_Pop_Out  = Reset_In && (state_q == CAPT) && (op_q == OP_POP);

  assign bus.Stk_Data_Out = wdata_q;
  assign bus.Ack_Out      = ack_q;
  assign bus.Err_Out      = err_q;
  assign bus.Rd_Data_Out  = rd_data_q;
  assign bus.Busy_Out     = (state_q != IDLE);

  // Next-state and next-output logic for the IDLE/EXEC/CAPT/RESP sequence.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    win_d     = win_q;
    win_oh_d  = win_oh_q;
    op_d      = op_q;
    wdata_d   = wdata_q;
    ack_d     = '0;
    err_d     = 1'b0;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          win_d    = grant_idx;
          win_oh_d = grant;
          op_d     = op_t'(bus.Op_In[2*grant_idx +: 2]);
          wdata_d  = bus.Wr_Data_In[DATA_WIDTH*grant_idx +: DATA_WIDTH];
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (exec_read_ok) begin
          state_d = CAPT;
        end else begin
          // Push (ok or full), rejected pop/peek, or reserved opcode: respond now.
          state_d   = RESP;
          ack_d     = win_oh_q;
          err_d     = !exec_push_ok;
          rd_data_d = '0;
        end
      end
      CAPT: begin
        state_d   = RESP;
        ack_d     = win_oh_q;
        err_d     = 1'b0;
        rd_data_d = bus.Stk_Data_In;
      end
      RESP: begin
        rr_d    = IDX_W'(next_client(int'(win_q), NUM_CLIENTS));
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clk_In) begin
    if (!Reset_In) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      win_q     <= '0;
      win_oh_q  <= '0;
      op_q      <= OP_NOP;
      wdata_q   <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      win_q     <= win_d;
      win_oh_q  <= win_oh_d;
      op_q      <= op_d;
      wdata_q   <= wdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_lifo_stack_arbiter.sv
// tb/tb_lifo_stack_arbiter.sv - directed self-checking bench for lifo_stack_arbiter
module tb_lifo_stack_arbiter;
  import lifo_arb_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  lifo_stack_arbiter_if #(.DATA_WIDTH(32), .NUM_CLIENTS(2)) bus ();

  lifo_stack_arbiter #(.DATA_WIDTH(32), .NUM_CLIENTS(2)) dut (
    .Clk_In   (clk),
    .Reset_In (rst_n),
    .bus      (bus)
  );

  // 8-deep stack model: registered read data valid the cycle after a peek
  logic [31:0] mem [8];
  int          sp     = 0;
  logic [31:0] stk_rd = '0;

  assign bus.Stk_Data_In  = stk_rd;
  assign bus.Stk_Empty_In = (sp == 0);
  assign bus.Stk_Full_In  = (sp == 8);

  always @(posedge clk) begin
    if (bus.Stk_Push_Out && sp < 8) begin
      mem[sp] <= bus.Stk_Data_Out;
      sp      <= sp + 1;
    end
    if (bus.Stk_Peek_Out && sp > 0) stk_rd <= mem[sp-1];
    if (bus.Stk_Pop_Out && sp > 0) sp <= sp - 1;
  end

  function automatic logic [31:0] fair_val(input int j);
    return 32'hF000_0000 | (32'(j % 2) << 8) | 32'(j / 2);
  endfunction

  // Issue one request from client c and wait for its acknowledge.
  task automatic do_op(input int c, input logic [1:0] op, input logic [31:0] d,
                       output logic [1:0] ack, output logic err, output logic [31:0] rd,
                       output int lat, output logic saw_push, output logic saw_peek,
                       output logic saw_pop, output logic [31:0] push_data);
    int  nst;
    bit  done;
    @(negedge clk);
    tests++;
    if (bus.Busy_Out !== 1'b0) begin
      fails++;
      $display("FAIL busy_before_req: got %b expected 0", bus.Busy_Out);
    end
    bus.Req_In[c]          = 1'b1;
    bus.Op_In[2*c +: 2]    = op;
    bus.Wr_Data_In[32*c +: 32] = d;
    ack = '0; err = 1'b0; rd = '0; lat = 0; done = 1'b0;
    saw_push = 1'b0; saw_peek = 1'b0; saw_pop = 1'b0; push_data = '0;
    for (int i = 1; i <= 10 && !done; i++) begin
      @(negedge clk);
      nst = int'(bus.Stk_Push_Out) + int'(bus.Stk_Pop_Out) + int'(bus.Stk_Peek_Out);
      tests++;
      if (nst > 1) begin
        fails++;
        $display("FAIL strobe_exclusive: got %0d strobes expected <=1", nst);
      end
      if (bus.Stk_Push_Out) begin saw_push = 1'b1; push_data = bus.Stk_Data_Out; end
      if (bus.Stk_Peek_Out) saw_peek = 1'b1;
      if (bus.Stk_Pop_Out)  saw_pop  = 1'b1;
      if (bus.Ack_Out != '0) begin
        ack = bus.Ack_Out; err = bus.Err_Out; rd = bus.Rd_Data_Out; lat = i;
        done = 1'b1;
        bus.Req_In[c] = 1'b0;
      end
    end
    tests++;
    if (!done) begin
      fails++;
      bus.Req_In[c] = 1'b0;
      $display("FAIL ack_timeout: got no ack expected ack within 10 cycles");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.Req_In = 2'b11;
    bus.Op_In  = {OP_PUSH, OP_PUSH};
    bus.Wr_Data_In = {32'h0000_00A1, 32'h0000_00A0};
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({bus.Ack_Out, bus.Err_Out, bus.Busy_Out} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got ack=%b err=%b busy=%b expected 0", bus.Ack_Out, bus.Err_Out, bus.Busy_Out);
    end
    tests++;
    if (bus.Rd_Data_Out !== 32'h0 || bus.Stk_Data_Out !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: got rd=%h stk=%h expected 0", bus.Rd_Data_Out, bus.Stk_Data_Out);
    end
    tests++;
    if ({bus.Stk_Push_Out, bus.Stk_Pop_Out, bus.Stk_Peek_Out} !== 3'b000) begin
      fails++;
      $display("FAIL reset_strobes: got %b expected 000", {bus.Stk_Push_Out, bus.Stk_Pop_Out, bus.Stk_Peek_Out});
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.Stk_Push_Out !== 1'b1 || bus.Stk_Data_Out !== 32'h0000_00A0) begin
      fails++;
      $display("FAIL reset_first_grant: got push=%b data=%h expected 1 000000a0", bus.Stk_Push_Out, bus.Stk_Data_Out);
    end
    bus.Req_In[1] = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.Ack_Out !== 2'b01 || bus.Err_Out !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_ack: got ack=%b err=%b expected 01 0", bus.Ack_Out, bus.Err_Out);
    end
    bus.Req_In = 2'b00;
  endtask

  task automatic test_push();
    logic [1:0] ack; logic err, sp_, pk, pp; logic [31:0] rd, pd; int lat;
    do_op(0, OP_NOP, 32'h0, ack, err, rd, lat, sp_, pk, pp, pd);
    tests++;
    if (ack !== 2'b01 || err !== 1'b1 || rd !== 32'h0 || lat != 2 || {sp_, pk, pp} !== 3'b000) begin
      fails++;
      $display("FAIL nop_err: got ack=%b err=%b rd=%h lat=%0d stb=%b%b%b expected 01 1 0 2 000", ack, err, rd, lat, sp_, pk, pp);
    end
    do_op(0, OP_PUSH, 32'hDEAD_BEEF, ack, err, rd, lat, sp_, pk, pp, pd);
    tests++;
    if (ack !== 2'b01 || err !== 1'b0 || lat != 2 || sp_ !== 1'b1 || pd !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL push: got ack=%b err=%b lat=%0d push=%b data=%h expected 01 0 2 1 deadbeef", ack, err, lat, sp_, pd);
    end
  endtask

  task automatic test_pop();
    logic [1:0] ack; logic err, sp_, pk, pp; logic [31:0] rd, pd; int lat;
    do_op(0, OP_PUSH, 32'h1234_5678, ack, err, rd, lat, sp_, pk, pp, pd);
    do_op(1, OP_PEEK, 32'h0, ack, err, rd, lat, sp_, pk, pp, pd);
    tests++;
    if (ack !== 2'b10 || err !== 1'b0 || rd !== 32'h1234_5678 || lat != 3 || {pk, pp} !== 2'b10) begin
      fails++;
      $display("FAIL peek: got ack=%b err=%b rd=%h lat=%0d peek=%b pop=%b expected 10 0 12345678 3 1 0", ack, err, rd, lat, pk, pp);
    end
    do_op(1, OP_POP, 32'h0, ack, err, rd, lat, sp_, pk, pp, pd);
    tests++;
    if (ack !== 2'b10 || err !== 1'b0 || rd !== 32'h1234_5678 || lat != 3 || {pk, pp} !== 2'b11) begin
      fails++;
      $display("FAIL pop: got ack=%b err=%b rd=%h lat=%0d peek=%b pop=%b expected 10 0 12345678 3 1 1", ack, err, rd, lat, pk, pp);
    end
    do_op(1, OP_POP, 32'h0, ack, err, rd, lat, sp_, pk, pp, pd);
    tests++;
    if (rd !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL pop2: got %h expected deadbeef", rd);
    end
    do_op(1, OP_POP, 32'h0, ack, err, rd, lat, sp_, pk, pp, pd);
    tests++;
    if (rd !== 32'h0000_00A0 || sp != 0) begin
      fails++;
      $display("FAIL pop3: got rd=%h depth=%0d expected 000000a0 0", rd, sp);
    end
  endtask

  task automatic test_fairness();
    int  nst; bit done; logic [1:0] want;
    logic [31:0] pd;
    @(negedge clk);
    bus.Op_In      = {OP_PUSH, OP_PUSH};
    bus.Wr_Data_In = {fair_val(1), fair_val(0)};
    bus.Req_In     = 2'b11;
    pd = '0;
    for (int j = 0; j < 8; j++) begin
      done = 1'b0;
      for (int i = 0; i < 10 && !done; i++) begin
        @(negedge clk);
        nst = int'(bus.Stk_Push_Out) + int'(bus.Stk_Pop_Out) + int'(bus.Stk_Peek_Out);
        tests++;
        if (nst > 1) begin
          fails++;
          $display("FAIL fair_strobe_exclusive: got %0d expected <=1", nst);
        end
        if (bus.Stk_Push_Out) pd = bus.Stk_Data_Out;
        if (bus.Ack_Out != '0) done = 1'b1;
      end
      want = (j % 2 == 0) ? 2'b01 : 2'b10;
      tests++;
      if (!done || bus.Ack_Out !== want || pd !== fair_val(j)) begin
        fails++;
        $display("FAIL fair_order_%0d: got ack=%b data=%h expected %b %h", j, bus.Ack_Out, pd, want, fair_val(j));
      end
      if (j + 2 < 8) bus.Wr_Data_In[32*(j%2) +: 32] = fair_val(j + 2);
      if (j == 7) bus.Req_In = 2'b00;
    end
    bus.Req_In = 2'b00;
  endtask

  task automatic test_full_empty();
    logic [1:0] ack; logic err, sp_, pk, pp; logic [31:0] rd, pd; int lat;
    do_op(0, OP_PUSH, 32'hBAD0_BAD0, ack, err, rd, lat, sp_, pk, pp, pd);
    tests++;
    if (ack !== 2'b01 || err !== 1'b1 || sp_ !== 1'b0 || lat != 2 || sp != 8) begin
      fails++;
      $display("FAIL full_push: got ack=%b err=%b push=%b lat=%0d depth=%0d expected 01 1 0 2 8", ack, err, sp_, lat, sp);
    end
    for (int i = 0; i < 8; i++) begin
      do_op(1, OP_POP, 32'h0, ack, err, rd, lat, sp_, pk, pp, pd);
      tests++;
      if (err !== 1'b0 || rd !== fair_val(7 - i)) begin
        fails++;
        $display("FAIL drain_%0d: got err=%b rd=%h expected 0 %h", i, err, rd, fair_val(7 - i));
      end
    end
    do_op(1, OP_POP, 32'h0, ack, err, rd, lat, sp_, pk, pp, pd);
    tests++;
    if (ack !== 2'b10 || err !== 1'b1 || rd !== 32'h0 || {pk, pp} !== 2'b00 || lat != 2) begin
      fails++;
      $display("FAIL empty_pop: got ack=%b err=%b rd=%h peek=%b pop=%b lat=%0d expected 10 1 0 0 0 2", ack, err, rd, pk, pp, lat);
    end
  endtask

  task automatic test_abort();
    logic [1:0] ack; logic err, sp_, pk, pp; logic [31:0] rd, pd; int lat;
    do_op(0, OP_PUSH, 32'h0000_0055, ack, err, rd, lat, sp_, pk, pp, pd);
    @(negedge clk);
    bus.Req_In[0]   = 1'b1;
    bus.Op_In[1:0]  = OP_POP;
    @(negedge clk);
    tests++;
    if (bus.Stk_Peek_Out !== 1'b1) begin
      fails++;
      $display("FAIL abort_peek: got %b expected 1", bus.Stk_Peek_Out);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.Stk_Pop_Out !== 1'b0 || bus.Busy_Out !== 1'b1) begin
      fails++;
      $display("FAIL abort_capt: got pop=%b busy=%b expected 0 1", bus.Stk_Pop_Out, bus.Busy_Out);
    end
    bus.Req_In = 2'b00;
    @(negedge clk);
    tests++;
    if (bus.Busy_Out !== 1'b0 || bus.Ack_Out !== 2'b00 ||
        {bus.Stk_Push_Out, bus.Stk_Pop_Out, bus.Stk_Peek_Out} !== 3'b000 || sp != 1) begin
      fails++;
      $display("FAIL abort_idle: got busy=%b ack=%b depth=%0d expected 0 00 1", bus.Busy_Out, bus.Ack_Out, sp);
    end
    rst_n = 1'b1;
    do_op(0, OP_PEEK, 32'h0, ack, err, rd, lat, sp_, pk, pp, pd);
    tests++;
    if (ack !== 2'b01 || err !== 1'b0 || rd !== 32'h0000_0055 || lat != 3) begin
      fails++;
      $display("FAIL abort_after_peek: got ack=%b err=%b rd=%h lat=%0d expected 01 0 00000055 3", ack, err, rd, lat);
    end
  endtask

  initial begin
    bus.Req_In     = '0;
    bus.Op_In      = '0;
    bus.Wr_Data_In = '0;
    test_reset();
    test_push();
    test_pop();
    test_fairness();
    test_full_empty();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lifo_stack_arbiter.md
Name: lifo_stack_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 32-bit, 8-deep LIFO stack between NUM_CLIENTS requesters.
- Each client issues a push, pop or peek and receives a one-cycle acknowledge, with read data or an error flag.
- The block drives the stack's Push/Pop/Peek strobes and write data, and guarantees at most one stack operation per cycle.
- Pop is sequenced as peek-capture-pop.

Parameters:
DATA_WIDTH, 32, stack word width
NUM_CLIENTS, 2, number of requesters (legal 2..4)

Ports:
Clk_In  in  1  clock, rising edge
Reset_In  in  1  reset is synchronous and active-low
Req_In  in  NUM_CLIENTS  per-client request level
Op_In  in  2*NUM_CLIENTS  per-client opcode, client i at [2i+1:2i]; 01 push, 10 pop, 11 peek, 00 reserved
Wr_Data_In  in  DATA_WIDTH*NUM_CLIENTS  per-client push data, client i at [DATA_WIDTH*(i+1)-1:DATA_WIDTH*i]
Ack_Out  out  NUM_CLIENTS  one-hot, one-cycle completion pulse to the served client
Err_Out  out  1  qualified by Ack_Out; 1 = operation rejected
Rd_Data_Out  out  DATA_WIDTH  qualified by Ack_Out for pop/peek
Busy_Out  out  1  high whenever state != IDLE
Stk_Data_Out  out  DATA_WIDTH  write data to stack
Stk_Push_Out  out  1  stack push strobe
Stk_Pop_Out  out  1  stack pop strobe
Stk_Peek_Out  out  1  stack peek strobe
Stk_Data_In  in  DATA_WIDTH  stack read data; registered, valid the cycle after Peek
Stk_Empty_In  in  1  stack empty flag
Stk_Full_In  in  1  stack full flag

Behaviour:
- Reset (Reset_In=0 at a rising edge) sets:
  - state=IDLE, RR pointer=0.
  - Ack_Out=0, Err_Out=0, Rd_Data_Out=0, Busy_Out=0, Stk_Data_Out=0.
  - All Stk strobes 0 from the following cycle.
- Reset mid-transaction:
  - The transaction is aborted silently: no Ack, no further strobes.
  - Stack contents are not touched by the controller.
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE:
  - Req_In is sampled only here.
  - If any bit is set, the winner is the first set bit searching upward from RR, modulo NUM_CLIENTS.
  - Latch winner id, opcode and write data; go to EXEC.
- EXEC, push:
  - Stk_Full_In=1: no strobe, Err=1, go to RESP.
  - Otherwise: Stk_Push_Out=1 for this cycle, go to RESP.
- EXEC, pop/peek:
  - Stk_Empty_In=1: no strobe, Err=1, go to RESP.
  - Otherwise: Stk_Peek_Out=1, go to CAPT.
- EXEC, opcode 00: Err=1, go to RESP.
- CAPT:
  - Capture Stk_Data_In into the read register.
  - If opcode=pop, Stk_Pop_Out=1 this cycle.
  - Go to RESP.
- RESP:
  - Ack_Out[winner]=1, Err_Out valid.
  - Rd_Data_Out = captured word, or 0 on error or push.
  - RR <= (winner+1) mod NUM_CLIENTS; go to IDLE.
- Latency, measured from the IDLE cycle t in which Req is sampled:
  - Push or error: Ack at t+2.
  - Pop/peek: Ack at t+3.
  - Throughput: one transaction per 3 (push) or 4 (pop/peek) cycles.
- Client rule:
  - Hold Req_In until Ack.
  - Req_In still high in the IDLE cycle after Ack counts as a new request.
  - Op_In and Wr_Data_In need only be stable in the grant cycle.
- Strobe encoding:
  - Stk strobes are a combinational decode of state, latched opcode and the Stk flags; they are mutually exclusive.
  - Stk_Data_Out = latched write data, held between transactions.
- Output registers: Ack_Out, Err_Out and Rd_Data_Out are registered. Rd_Data_Out holds its value outside Ack cycles.
- Flags are checked in EXEC only. Simultaneous requests are resolved purely by RR; there is no priority inversion.

Decomposition:
- Package lifo_arb_pkg:
  - op_t enum: OP_NOP=2'b00, OP_PUSH=2'b01, OP_POP=2'b10, OP_PEEK=2'b11.
  - state_t enum: IDLE, EXEC, CAPT, RESP.
  - DATA_WIDTH default constant.
- Sub-module rr_arbiter: combinational round-robin picker, inputs Req vector and RR pointer, outputs one-hot grant plus index.

Test Plan:
1. Reset: hold Reset_In=0 for 2 cycles with Req_In=all ones -> all outputs 0, no strobes, Busy_Out=0; after release, client 0 is granted first.
2. Push: client 0 pushes 0xDEADBEEF, stack not full -> at t+1 Stk_Push_Out=1 with Stk_Data_Out=0xDEADBEEF; at t+2 Ack_Out=01, Err_Out=0.
3. Pop: client 1 pops, stack top=0x12345678 -> Stk_Peek_Out at t+1; Stk_Pop_Out at t+2; at t+3 Ack_Out=10, Rd_Data_Out=0x12345678. Peek instead -> same data, no Pop strobe.
4. Fairness: both clients hold push requests for 4 transactions each -> grant order 0,1,0,1,0,1,0,1; never two strobes in one cycle.
5. Full: push 9 values into the 8-deep stack -> 9th Ack has Err_Out=1 and no Stk_Push_Out. Empty: drain with 8 pops returning values in reverse order; 9th pop -> Err_Out=1, Rd_Data_Out=0, no Peek/Pop strobe.
6. Abort: assert Reset_In=0 during CAPT of a pop -> next cycle IDLE, no Stk_Pop_Out, no Ack; stack depth unchanged.
